missile_scheduler: RTL

MISSILE_SCHEDULER -- requirements
Module: missile_scheduler

---
 rtl/missile_scheduler.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/missile_scheduler.sv
// Launch scheduler for the player missile pool: motion tick generation,
// round-robin slot allocation, launch cooldown and slot retirement.
module missile_scheduler #(
  parameter int NUM_SLOTS      = 8,
  parameter int TICK_DIV       = 250000,
  parameter int COOLDOWN_TICKS = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         game_en,
  input  logic                         fire_btn,
  input  logic [NUM_SLOTS-1:0]         slot_done,
  input  logic                         hit_valid,
  input  logic [$clog2(NUM_SLOTS)-1:0] hit_slot,
  output logic [NUM_SLOTS-1:0]         missile_en,
  output logic                         fire_ack,
  output logic [$clog2(NUM_SLOTS)-1:0] fire_slot,
  output logic                         fire_drop,
  output logic                         move_tick,
  output logic [$clog2(NUM_SLOTS):0]   active_cnt
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CD_W   = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [CD_W-1:0]   CD_LOAD   = CD_W'(COOLDOWN_TICKS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_COOLDOWN
  } state_t;

  state_t              r_state;
  logic [TICK_W-1:0]   r_tick_cnt;
  logic [CD_W-1:0]     r_cd_cnt;
  logic                r_btn_d;
  logic                r_btn_armed;
  logic [SLOT_W-1:0]   r_rr_ptr;
  logic [SLOT_W-1:0]   r_sel;
  logic [NUM_SLOTS-1:0] r_en;
  logic [SLOT_W:0]     r_cnt;
  logic                r_ack;
  logic [SLOT_W-1:0]   r_slot;
  logic                r_drop;
  logic                r_move;

  logic                 w_req;
  logic                 w_any_free;
  logic [SLOT_W-1:0]    w_pick;
  logic [NUM_SLOTS-1:0] w_retire;
  logic [NUM_SLOTS-1:0] w_en_next;

  // First free slot at or above ptr, wrapping modulo the slot count.
  function automatic logic [SLOT_W-1:0] f_pick(input logic [NUM_SLOTS-1:0] busy,
                                               input logic [SLOT_W-1:0]    ptr);
    logic [SLOT_W-1:0] idx;
    f_pick = ptr;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      idx = ptr + SLOT_W'(k);
      if (!busy[idx]) f_pick = idx;
    end
  endfunction

  function automatic logic [SLOT_W:0] f_popcnt(input logic [NUM_SLOTS-1:0] v);
    logic [SLOT_W:0] n;
    n = '0;
    for (int i = 0; i < NUM_SLOTS; i++) n = n + {{SLOT_W{1'b0}}, v[i]};
    return n;
  endfunction

  // A button already held at reset release must be seen low once before it can fire.
  assign w_req      = fire_btn & ~r_btn_d & r_btn_armed;
  assign w_any_free = ~&r_en;
  assign w_pick     = f_pick(r_en, r_rr_ptr);
  assign w_retire   = slot_done | (hit_valid ? (NUM_SLOTS'(1) << hit_slot) : '0);
  assign w_en_next  = (r_en & ~w_retire) |
                      ((r_state == S_LAUNCH) ? (NUM_SLOTS'(1) << r_sel) : '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_tick_cnt  <= '0;
      r_cd_cnt    <= '0;
      r_btn_d     <= 1'b0;
      r_btn_armed <= 1'b0;
      r_rr_ptr    <= '0;
      r_sel       <= '0;
      r_en        <= '0;
      r_cnt       <= '0;
      r_ack       <= 1'b0;
      r_slot      <= '0;
      r_drop      <= 1'b0;
      r_move      <= 1'b0;
    end else begin
      r_btn_d     <= fire_btn;
      r_btn_armed <= r_btn_armed | ~fire_btn;
      r_ack       <= 1'b0;
      r_drop      <= 1'b0;
      if (!game_en) begin
        r_state    <= S_IDLE;
        r_tick_cnt <= '0;
        r_cd_cnt   <= '0;
        r_move     <= 1'b0;
        r_en       <= '0;
        r_cnt      <= '0;
      end else begin
        r_move     <= (r_tick_cnt == TICK_LAST);
        r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + 1'b1;
        r_en       <= w_en_next;
        r_cnt      <= f_popcnt(w_en_next);
        case (r_state)
          S_IDLE: begin
            if (w_req) begin
              if (w_any_free) begin
                r_sel   <= w_pick;
                r_state <= S_LAUNCH;
              end else begin
                r_drop  <= 1'b1;
              end
            end
          end
          S_LAUNCH: begin
            r_ack    <= 1'b1;
            r_slot   <= r_sel;
            r_rr_ptr <= r_sel + 1'b1;
            r_cd_cnt <= CD_LOAD;
            r_state  <= S_COOLDOWN;
          end
          S_COOLDOWN: begin
            if (r_cd_cnt == '0)  r_state  <= S_IDLE;
            else if (r_move)     r_cd_cnt <= r_cd_cnt - 1'b1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign missile_en = r_en;
  assign fire_ack   = r_ack;
  assign fire_slot  = r_slot;
  assign fire_drop  = r_drop;
  assign move_tick  = r_move;
  assign active_cnt = r_cnt;

endmodule
